button_debounce: RTL and testbench

Conditions the raw `PANO_BUTTON` input into clean, single-cycle event strobes for the rest of the design. It sits on the input side of the board I/O, opposite the LED drivers. The block does three things:
- synchronises the asynchronous pad into the `SYSCLK` domain;
- debounces it with a stable-count filter;
- classifies each press as a click or a long press, and keeps a wrapping press counter.

---
 rtl/button_debounce_if.sv | 27 ++
 rtl/button_debounce.sv | 157 +++++++++++++++
 tb/tb_button_debounce.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Debounced button event bundle: level, edge strobes, click/long classification and press counter.
interface button_debounce_if;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  modport master (
    output pressed,
    output press_pulse,
    output release_pulse,
    output click_pulse,
    output long_pulse,
    output press_count
  );

  modport slave (
    input pressed,
    input press_pulse,
    input release_pulse,
    input click_pulse,
    input long_pulse,
    input press_count
  );
endinterface

// File: rtl/button_debounce.sv
// Button conditioner: 2-flop sync, stable-count debounce, click/long FSM and wrapping press counter.
// Latency pad->press/release strobe is 2 + DEBOUNCE_CYCLES edges; no backpressure, strobes are 1 cycle.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic               SYSCLK,
  input  logic               RST_N,
  input  logic               PANO_BUTTON,
  button_debounce_if.master  evt_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LMAX = HW'(LONG_CYCLES - 1);
  // Pad level that means "released"; sync flops reset here so reset exit never looks like a press.
  localparam logic PAD_IDLE = ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  logic          sync1_q, sync2_q;
  logic          btn_s;

  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [7:0]    count_q, count_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          click_q, click_d;
  logic          long_q, long_d;

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= PAD_IDLE;
      sync2_q <= PAD_IDLE;
    end else begin
      sync1_q <= PANO_BUTTON;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q ^ PAD_IDLE;

  // Any cycle of agreement restarts the count, so only an unbroken run can flip the state.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (btn_s != deb_q) begin
      if (dcnt_q == DMAX) begin
        deb_d  = btn_s;
        rise_d = btn_s;
        fall_d = ~btn_s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_q  <= 1'b0;
      dcnt_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise_q) begin
          state_d = S_HELD;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
          hcnt_d  = '0;
        end
      end
      S_HELD: begin
        // Release is checked first so a release on the threshold cycle is still a click.
        if (fall_q) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (hcnt_q == LMAX) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_LONG: begin
        if (fall_q) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pressed_d = (state_d != S_IDLE);
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      count_q   <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      count_q   <= count_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
    end
  end

  assign evt_o.pressed       = pressed_q;
  assign evt_o.press_pulse   = press_q;
  assign evt_o.release_pulse = release_q;
  assign evt_o.click_pulse   = click_q;
  assign evt_o.long_pulse    = long_q;
  assign evt_o.press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Randomised scoreboard bench for button_debounce with a window-based reference model.
module tb_button_debounce;
  localparam int D = 4;
  localparam int L = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pad   = 1'b0;

  always #5 clk = ~clk;

  button_debounce_if evt ();

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .SYSCLK     (clk),
    .RST_N      (rst_n),
    .PANO_BUTTON(pad),
    .evt_o      (evt)
  );

  typedef struct {
    int cyc;
    bit press;
    bit rel;
    bit click;
    bit lng;
    bit pressed;
    int count;
  } ev_t;

  ev_t expq[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  // Reference model: pressed-samples history, debounced level, hold bookkeeping.
  bit       hist[1024];
  bit       level;
  bit       held;
  bit       longd;
  int       press_edge;
  int       mcount;
  bit       all_diff;
  ev_t      e;
  logic [9:0] idx;

  task automatic model_reset();
    foreach (hist[i]) hist[i] = 1'b0;
    level  = 1'b0;
    held   = 1'b0;
    longd  = 1'b0;
    mcount = 0;
  endtask

  // A level flips at edge t when the last D synchronised samples (pad at t-2 .. t-1-D) all oppose it;
  // the FSM reports it one edge later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
      end else begin
        idx = 10'(cyc);
        hist[idx] = ~pad;
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          idx = 10'(cyc - 2 - j);
          if (hist[idx] == level) all_diff = 1'b0;
        end
        e = '{cyc: cyc + 1, press: 0, rel: 0, click: 0, lng: 0, pressed: 0, count: 0};
        if (all_diff) begin
          level = ~level;
          if (level) begin
            mcount++;
            held = 1'b1; longd = 1'b0; press_edge = cyc + 1;
            e.press = 1'b1; e.pressed = 1'b1;
          end else begin
            e.rel   = 1'b1;
            e.click = held && !longd && (cyc + 1 <= press_edge + L);
            held    = 1'b0;
          end
          e.count = mcount % 256;
          expq.push_back(e);
        end else if (held && !longd && (cyc + 1 == press_edge + L)) begin
          longd = 1'b1;
          e.lng = 1'b1; e.pressed = 1'b1; e.count = mcount % 256;
          expq.push_back(e);
        end
      end
    end
  end

  ev_t m;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
          tests++; fails++;
          $display("FAIL missing_event: DUT silent at cycle %0d, expected p/r/c/l=%b%b%b%b",
                   expq[0].cyc, expq[0].press, expq[0].rel, expq[0].click, expq[0].lng);
          void'(expq.pop_front());
        end
        if (evt.press_pulse || evt.release_pulse || evt.click_pulse || evt.long_pulse) begin
          tests++;
          if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: cycle %0d got p/r/c/l=%b%b%b%b, expected no strobe",
                     cyc, evt.press_pulse, evt.release_pulse, evt.click_pulse, evt.long_pulse);
          end else begin
            m = expq.pop_front();
            if (m.cyc != cyc || evt.press_pulse !== m.press || evt.release_pulse !== m.rel ||
                evt.click_pulse !== m.click || evt.long_pulse !== m.lng ||
                evt.pressed !== m.pressed || evt.press_count !== 8'(m.count)) begin
              fails++;
              $display("FAIL event: got cyc=%0d p/r/c/l=%b%b%b%b pressed=%b cnt=%0d, expected cyc=%0d p/r/c/l=%b%b%b%b pressed=%b cnt=%0d",
                       cyc, evt.press_pulse, evt.release_pulse, evt.click_pulse, evt.long_pulse,
                       evt.pressed, evt.press_count, m.cyc, m.press, m.rel, m.click, m.lng,
                       m.pressed, m.count);
            end
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    tests++;
    if ({evt.pressed, evt.press_pulse, evt.release_pulse, evt.click_pulse, evt.long_pulse} !== 5'b0 ||
        evt.press_count !== 8'd0) begin
      fails++;
      $display("FAIL %s: got pressed=%b p/r/c/l=%b%b%b%b cnt=%0d, expected all zero", name,
               evt.pressed, evt.press_pulse, evt.release_pulse, evt.click_pulse, evt.long_pulse,
               evt.press_count);
    end
  endtask

  // Only call after the pad has been stable long enough for the model and DUT to agree.
  task automatic check_state(input string name);
    tests++;
    if (evt.pressed !== held || evt.press_count !== 8'(mcount)) begin
      fails++;
      $display("FAIL %s: got pressed=%b cnt=%0d, expected pressed=%b cnt=%0d", name,
               evt.pressed, evt.press_count, held, mcount % 256);
    end
  endtask

  task automatic check_count(input string name, input logic [7:0] want);
    tests++;
    if (evt.press_count !== want) begin
      fails++;
      $display("FAIL %s: got cnt=%0d, expected cnt=%0d", name, evt.press_count, want);
    end
  endtask

  task automatic hold(input logic v, input int n);
    pad = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    expq.delete();
    model_reset();
    repeat (n) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_release_edge");
    @(negedge clk);
  endtask

  initial begin
    // Reset with the pad already pressed: a press must follow reset exit.
    repeat (3) @(negedge clk);
    check_zero("reset_initial");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_first_edge");
    @(negedge clk);
    hold(1'b0, 12);
    check_state("press_after_reset");
    check_count("press_after_reset_cnt", 8'd1);
    hold(1'b1, 12);
    check_state("release_after_reset");

    // Glitch rejection.
    apply_reset(2);
    for (int i = 0; i < 10; i++) begin
      hold(1'b0, 3);
      hold(1'b1, 3);
    end
    hold(1'b1, 10);
    check_state("glitch_reject");
    check_count("glitch_cnt", 8'd0);

    // Click.
    hold(1'b0, 10);
    hold(1'b1, 12);
    check_state("click");

    // Long press.
    hold(1'b0, 40);
    check_state("long_held");
    hold(1'b1, 12);
    check_state("long_release");

    // Counter wrap.
    apply_reset(2);
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, 8);
      hold(1'b1, 8);
      if (i == 254) check_count("wrap_255", 8'd255);
      if (i == 255) check_count("wrap_0", 8'd0);
    end
    check_state("wrap_state");

    // Asynchronous reset while in the long state, pad kept pressed.
    hold(1'b0, 30);
    apply_reset(3);
    hold(1'b0, 12);
    check_state("press_after_midhold_reset");
    hold(1'b1, 12);
    check_state("release_after_midhold_reset");

    // Random pad activity with occasional resets.
    for (int i = 0; i < 400; i++) begin
      int len;
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 35)) : int'($urandom_range(1, 10));
      hold(1'(i % 2), len);
      if ($urandom_range(0, 60) == 0) apply_reset(int'($urandom_range(1, 4)));
    end
    hold(1'b1, 30);
    check_state("random_end");

    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending events, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
